// File: rtl/sequential_divider_if.sv
// Operand/result bundle for the sequential divider; shared shape with the
// shift-add multiplier so a single harness can drive either block.
interface sequential_divider_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is sampled on a rising edge only while the block is idle
  // (ready may be 0 or 1). ready=1 means Quotient/Remainder/flags are valid and
  // a new start will be taken; ready drops on the edge that accepts start.
  logic             start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             ready;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, Dividend, Divisor,
    input  ready, Quotient, Remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, Dividend, Divisor,
    output ready, Quotient, Remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/sequential_divider.sv
// Iterative signed divider: restoring radix-2 on operand magnitudes, one bit
// per cycle, then a single sign-correction cycle. C-style truncating results.
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sequential_divider_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dvs_mag_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             dbz_pend_q;
  logic             ovf_pend_q;
  logic             ready_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             accept;
  logic             div_zero_in;
  logic             ovf_in;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  assign accept      = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign div_zero_in = (bus.Divisor == '0);
  assign ovf_in      = (bus.Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Divisor == '1);

  // Magnitudes are unsigned, so |-32768| = 16'h8000 is exact.
  assign dvd_mag = bus.Dividend[WIDTH-1] ? (~bus.Dividend + WIDTH'(1)) : bus.Dividend;
  assign dvs_mag = bus.Divisor[WIDTH-1]  ? (~bus.Divisor  + WIDTH'(1)) : bus.Divisor;

  // Shift {R,Q} left one place and try to subtract the divisor magnitude.
  assign r_sh      = {rem_q, quo_q[WIDTH-1]};
  assign trial     = r_sh - {1'b0, dvs_mag_q};
  assign trial_neg = trial[WIDTH+1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        // Divide-by-zero skips the iterations but still passes through FIX,
        // so its result appears one edge after capture.
        if (accept) state_d = div_zero_in ? FIX : CALC;
      end
      CALC: begin
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_mag_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            dvs_mag_q <= {1'b0, dvs_mag};
            if (div_zero_in) begin
              // Preload the fixed zero-divisor answer; FIX passes it through.
              quo_q      <= '1;
              rem_q      <= {bus.Dividend[WIDTH-1], bus.Dividend};
              neg_q_q    <= 1'b0;
              neg_r_q    <= 1'b0;
              dbz_pend_q <= 1'b1;
              ovf_pend_q <= 1'b0;
            end else begin
              quo_q      <= dvd_mag;
              rem_q      <= '0;
              neg_q_q    <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
              neg_r_q    <= bus.Dividend[WIDTH-1];
              dbz_pend_q <= 1'b0;
              ovf_pend_q <= ovf_in;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          quo_q <= {quo_q[WIDTH-2:0], ~trial_neg};
          rem_q <= trial_neg ? r_sh[WIDTH:0] : trial[WIDTH:0];
        end
        FIX: begin
          ready_q     <= 1'b1;
          quotient_q  <= neg_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder_q <= neg_r_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
          dbz_q       <= dbz_pend_q;
          ovf_q       <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.Quotient    = quotient_q;
  assign bus.Remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign dbg_state_o     = state_q;

endmodule
